// File: rtl/commit_pkg.sv
// Shared types and reset constants for the commit trace unit.
package commit_pkg;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        ctrl;
    logic        mispred;
  } commit_entry_t;

  typedef enum logic [1:0] {
    CntCycle   = 2'd0,
    CntInsn    = 2'd1,
    CntCtrl    = 2'd2,
    CntMispred = 2'd3
  } cnt_sel_e;

  localparam commit_entry_t EntryReset = '0;
  localparam logic [31:0]   CntReset   = 32'h0000_0000;

endpackage

// File: rtl/commit_perf_cnt.sv
// Commit performance counters (cycle, insn, ctrl, mispred) with a registered read port.
module commit_perf_cnt
  import commit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_clr,
  input  logic [1:0]  cnt_addr,
  input  logic        insn,
  input  logic        ctrl,
  input  logic        mispred,
  output logic [31:0] rdata
);

  logic [31:0] cycle_q, insn_q, ctrl_q, mispred_q;
  logic [31:0] rdata_q, rdata_d;

  // Read mux sees the values held at this edge, before this cycle's increment.
  always_comb begin
    rdata_d = CntReset;
    unique case (cnt_sel_e'(cnt_addr))
      CntCycle:   rdata_d = cycle_q;
      CntInsn:    rdata_d = insn_q;
      CntCtrl:    rdata_d = ctrl_q;
      CntMispred: rdata_d = mispred_q;
      default:    rdata_d = CntReset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q   <= CntReset;
      insn_q    <= CntReset;
      ctrl_q    <= CntReset;
      mispred_q <= CntReset;
      rdata_q   <= CntReset;
    end else begin
      rdata_q <= rdata_d;
      if (cnt_clr) begin
        cycle_q   <= CntReset;
        insn_q    <= CntReset;
        ctrl_q    <= CntReset;
        mispred_q <= CntReset;
      end else begin
        cycle_q   <= cycle_q + 32'd1;
        insn_q    <= insn_q + 32'(insn);
        ctrl_q    <= ctrl_q + 32'(ctrl);
        mispred_q <= mispred_q + 32'(mispred);
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/commit_trace.sv
// Commit trace: MEM/WB tracking stages driving a one-pulse-per-instruction commit trace.
// Performance counters are built only when COMMIT_PERF_CNT_EN is defined.
module commit_trace
  import commit_pkg::*;
#(
  parameter logic [31:0] HALT_PC = 32'h0000_001C
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_kill_ex,
  input  logic        i_ex_vld,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_ctrl,
  input  logic        i_ex_mispred,
  input  logic        i_cnt_clr,
  input  logic [1:0]  i_cnt_addr,
  output logic        o_insn_vld,
  output logic [31:0] o_pc_debug,
  output logic        o_ctrl,
  output logic        o_mispred,
  output logic        o_halt,
  output logic [31:0] o_cnt_rdata
);

  commit_entry_t mem_q, mem_d;
  commit_entry_t wb_q, wb_d;
  logic          halt_q, halt_d;

  always_comb begin
    mem_d  = mem_q;
    wb_d   = mem_q;
    halt_d = halt_q | (wb_q.vld && (wb_q.pc == HALT_PC));
    if (!i_stall) begin
      mem_d.vld     = i_ex_vld & ~i_kill_ex;
      mem_d.pc      = i_ex_pc;
      mem_d.ctrl    = i_ex_ctrl;
      mem_d.mispred = i_ex_mispred;
    end else begin
      // MEM is frozen; WB gets a bubble so the held instruction commits only once.
      wb_d.vld = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      mem_q  <= EntryReset;
      wb_q   <= EntryReset;
      halt_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      halt_q <= halt_d;
    end
  end

  assign o_insn_vld = wb_q.vld;
  assign o_pc_debug = wb_q.pc;
  assign o_ctrl     = wb_q.vld & wb_q.ctrl;
  assign o_mispred  = wb_q.vld & wb_q.ctrl & wb_q.mispred;
  assign o_halt     = halt_q;

`ifdef COMMIT_PERF_CNT_EN
  commit_perf_cnt u_perf (
    .clk      (i_clk),
    .reset    (i_reset),
    .cnt_clr  (i_cnt_clr),
    .cnt_addr (i_cnt_addr),
    .insn     (o_insn_vld),
    .ctrl     (o_ctrl),
    .mispred  (o_mispred),
    .rdata    (o_cnt_rdata)
  );
`else
  logic unused_cnt;
  assign unused_cnt  = ^{i_cnt_clr, i_cnt_addr};
  assign o_cnt_rdata = CntReset;
`endif

endmodule

// File: tb/tb_commit_trace.sv
// Self-checking bench for commit_trace: directed scenario tasks plus a commit scoreboard.
module tb_commit_trace;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_kill_ex;
  logic        i_ex_vld;
  logic [31:0] i_ex_pc;
  logic        i_ex_ctrl;
  logic        i_ex_mispred;
  logic        i_cnt_clr;
  logic [1:0]  i_cnt_addr;
  logic        o_insn_vld;
  logic [31:0] o_pc_debug;
  logic        o_ctrl;
  logic        o_mispred;
  logic        o_halt;
  logic [31:0] o_cnt_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic        ctrl;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  commit_trace #(.HALT_PC(32'h0000_001C)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_stall      (i_stall),
    .i_kill_ex    (i_kill_ex),
    .i_ex_vld     (i_ex_vld),
    .i_ex_pc      (i_ex_pc),
    .i_ex_ctrl    (i_ex_ctrl),
    .i_ex_mispred (i_ex_mispred),
    .i_cnt_clr    (i_cnt_clr),
    .i_cnt_addr   (i_cnt_addr),
    .o_insn_vld   (o_insn_vld),
    .o_pc_debug   (o_pc_debug),
    .o_ctrl       (o_ctrl),
    .o_mispred    (o_mispred),
    .o_halt       (o_halt),
    .o_cnt_rdata  (o_cnt_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard monitor: every commit pulse must match the oldest accepted instruction.
  always @(negedge i_clk) begin
    if (i_reset === 1'b1 && o_insn_vld === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_commit pc=%h (no instruction expected)", o_pc_debug);
      end else begin
        mon_e = sb.pop_front();
        if (o_pc_debug !== mon_e.pc || o_ctrl !== mon_e.ctrl || o_mispred !== mon_e.mis) begin
          errors++;
          $display("FAIL sb_commit got pc=%h ctrl=%b mis=%b want pc=%h ctrl=%b mis=%b",
                   o_pc_debug, o_ctrl, o_mispred, mon_e.pc, mon_e.ctrl, mon_e.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic issue(input logic [31:0] p, input logic c, input logic m);
    i_ex_vld     = 1'b1;
    i_ex_pc      = p;
    i_ex_ctrl    = c;
    i_ex_mispred = m;
    sb.push_back(exp_t'{pc: p, ctrl: c, mis: c & m});
    cyc();
    i_ex_vld     = 1'b0;
    i_ex_ctrl    = 1'b0;
    i_ex_mispred = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_stall = 1'b0; i_kill_ex = 1'b0; i_cnt_clr = 1'b0; i_cnt_addr = 2'd1;
    i_ex_vld = 1'b1; i_ex_pc = 32'h0000_001C; i_ex_ctrl = 1'b1; i_ex_mispred = 1'b1;
    repeat (3) cyc();
    checks++;
    if (o_insn_vld !== 1'b0 || o_ctrl !== 1'b0 || o_mispred !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got vld=%b ctrl=%b mis=%b want 0", o_insn_vld, o_ctrl, o_mispred);
    end
    checks++;
    if (o_pc_debug !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want 0", o_pc_debug);
    end
    checks++;
    if (o_halt !== 1'b0 || o_cnt_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_halt_cnt got halt=%b cnt=%h want 0", o_halt, o_cnt_rdata);
    end
    i_ex_vld = 1'b0; i_ex_ctrl = 1'b0; i_ex_mispred = 1'b0;
    i_reset = 1'b1;
    repeat (2) cyc();
    checks++;
    if (o_insn_vld !== 1'b0) begin
      errors++; $display("FAIL reset_release_vld got %b want 0", o_insn_vld);
    end
  endtask

  task automatic test_basic();
    issue(32'h40, 1'b0, 1'b0);
    checks++;
    if (o_insn_vld !== 1'b0) begin
      errors++; $display("FAIL basic_t1 got vld=%b want 0", o_insn_vld);
    end
    cyc();
    checks++;
    if (o_insn_vld !== 1'b1 || o_pc_debug !== 32'h40 || o_ctrl !== 1'b0) begin
      errors++;
      $display("FAIL basic_t2 got vld=%b pc=%h ctrl=%b want 1 00000040 0",
               o_insn_vld, o_pc_debug, o_ctrl);
    end
    cyc();
    checks++;
    if (o_insn_vld !== 1'b0) begin
      errors++; $display("FAIL basic_t3 got vld=%b want 0", o_insn_vld);
    end
  endtask

  task automatic test_stall();
    issue(32'h80, 1'b1, 1'b1);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (o_insn_vld !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got vld=%b want 0", k, o_insn_vld);
      end
    end
    i_stall = 1'b0;
    cyc();
    checks++;
    if (o_insn_vld !== 1'b1 || o_pc_debug !== 32'h80 || o_ctrl !== 1'b1 || o_mispred !== 1'b1) begin
      errors++;
      $display("FAIL stall_commit got vld=%b pc=%h ctrl=%b mis=%b want 1 00000080 1 1",
               o_insn_vld, o_pc_debug, o_ctrl, o_mispred);
    end
    cyc();
    checks++;
    if (o_insn_vld !== 1'b0) begin
      errors++; $display("FAIL stall_single_pulse got vld=%b want 0", o_insn_vld);
    end
    issue(32'h84, 1'b0, 1'b1);
    cyc();
    checks++;
    if (o_insn_vld !== 1'b1 || o_mispred !== 1'b0) begin
      errors++;
      $display("FAIL noctrl_mispred got vld=%b mis=%b want 1 0", o_insn_vld, o_mispred);
    end
  endtask

  task automatic test_kill();
    int pulses;
    pulses = 0;
    i_ex_vld = 1'b1; i_kill_ex = 1'b1; i_ex_pc = 32'h200;
    cyc();
    i_ex_vld = 1'b0; i_kill_ex = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (o_insn_vld === 1'b1) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL kill_no_commit got %0d pulses want 0", pulses);
    end
    // Kill while stalled must leave the held MEM instruction intact.
    issue(32'h204, 1'b1, 1'b0);
    i_stall = 1'b1; i_kill_ex = 1'b1; i_ex_vld = 1'b1; i_ex_pc = 32'h208;
    cyc();
    i_stall = 1'b0; i_kill_ex = 1'b0; i_ex_vld = 1'b0;
    cyc();
    checks++;
    if (o_insn_vld !== 1'b1 || o_pc_debug !== 32'h204) begin
      errors++;
      $display("FAIL kill_stalled got vld=%b pc=%h want 1 00000204", o_insn_vld, o_pc_debug);
    end
    cyc();
  endtask

  task automatic test_halt();
    checks++;
    if (o_halt !== 1'b0) begin
      errors++; $display("FAIL halt_before got %b want 0", o_halt);
    end
    issue(32'h1C, 1'b0, 1'b0);
    cyc();
    checks++;
    if (o_insn_vld !== 1'b1 || o_pc_debug !== 32'h1C || o_halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_commit got vld=%b pc=%h halt=%b want 1 0000001c 0",
               o_insn_vld, o_pc_debug, o_halt);
    end
    cyc();
    checks++;
    if (o_halt !== 1'b1) begin
      errors++; $display("FAIL halt_set got %b want 1", o_halt);
    end
    issue(32'h300, 1'b0, 1'b0);
    repeat (3) cyc();
    checks++;
    if (o_halt !== 1'b1) begin
      errors++; $display("FAIL halt_sticky got %b want 1", o_halt);
    end
  endtask

  task automatic test_counters();
    logic [9:0]  ctrl_set;
    logic [9:0]  mis_set;
    logic [31:0] want [1:3];
    ctrl_set = 10'b00_1010_1010;  // ctrl on 1,3,5,7
    mis_set  = 10'b01_0000_1000;  // mispred on 3 (ctrl) and 8 (not ctrl)
    want[1] = 32'd10; want[2] = 32'd4; want[3] = 32'd1;
    i_cnt_clr = 1'b1;
    cyc();
    i_cnt_clr = 1'b0;
    for (int k = 0; k < 10; k++) issue(32'h100 + 32'(4 * k), ctrl_set[k], mis_set[k]);
    repeat (3) cyc();
`ifdef COMMIT_PERF_CNT_EN
    for (int a = 1; a <= 3; a++) begin
      i_cnt_addr = 2'(a);
      cyc();
      checks++;
      if (o_cnt_rdata !== want[a]) begin
        errors++; $display("FAIL cnt_read%0d got %0d want %0d", a, o_cnt_rdata, want[a]);
      end
    end
    issue(32'h400, 1'b0, 1'b0);
    cyc();
    i_cnt_addr = 2'd1; i_cnt_clr = 1'b1;
    cyc();
    i_cnt_clr = 1'b0;
    cyc();
    checks++;
    if (o_cnt_rdata !== 32'h0) begin
      errors++; $display("FAIL cnt_clr_during_commit got %0d want 0", o_cnt_rdata);
    end
`else
    for (int a = 0; a < 4; a++) begin
      i_cnt_addr = 2'(a);
      i_cnt_clr  = a[0];
      cyc();
      checks++;
      if (o_cnt_rdata !== 32'h0) begin
        errors++; $display("FAIL cnt_disabled%0d got %h want 0", a, o_cnt_rdata);
      end
    end
    i_cnt_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_midop();
    int pulses;
    pulses = 0;
    issue(32'h500, 1'b1, 1'b1);
    issue(32'h504, 1'b0, 1'b0);
    i_ex_vld = 1'b1; i_ex_pc = 32'h508; i_cnt_addr = 2'd1;
    i_reset = 1'b0;
    cyc();
    i_reset = 1'b1; i_ex_vld = 1'b0;
    sb.delete();
    checks++;
    if (o_insn_vld !== 1'b0 || o_pc_debug !== 32'h0 || o_halt !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear got vld=%b pc=%h halt=%b want 0 0 0",
               o_insn_vld, o_pc_debug, o_halt);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (o_insn_vld === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midreset_no_commit got %0d pulses want 0", pulses);
    end
    checks++;
    if (o_cnt_rdata !== 32'h0) begin
      errors++; $display("FAIL midreset_cnt got %0d want 0", o_cnt_rdata);
    end
    issue(32'h600, 1'b0, 1'b0);
    cyc();
    checks++;
    if (o_insn_vld !== 1'b1 || o_pc_debug !== 32'h600) begin
      errors++;
      $display("FAIL midreset_fresh got vld=%b pc=%h want 1 00000600", o_insn_vld, o_pc_debug);
    end
    cyc();
  endtask

  task automatic test_wrap();
`ifdef COMMIT_PERF_CNT_EN
    bit seen;
    seen = 1'b0;
    i_cnt_addr = 2'd0;
    force dut.u_perf.cycle_q = 32'hFFFF_FFFE;
    cyc();
    release dut.u_perf.cycle_q;
    for (int k = 0; k < 6 && !seen; k++) begin
      cyc();
      if (o_cnt_rdata === 32'hFFFF_FFFF) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL wrap_max got %h want ffffffff", o_cnt_rdata);
    end
    cyc();
    checks++;
    if (o_cnt_rdata !== 32'h0) begin
      errors++; $display("FAIL wrap_zero got %h want 0", o_cnt_rdata);
    end
`else
    i_cnt_addr = 2'd0;
    repeat (2) cyc();
    checks++;
    if (o_cnt_rdata !== 32'h0) begin
      errors++; $display("FAIL wrap_disabled got %h want 0", o_cnt_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_kill();
    test_halt();
    test_counters();
    test_reset_midop();
    test_wrap();
    repeat (3) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace.md
COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 SHALL have parameter HALT_PC, default 32'h0000_001C, PC whose commit raises o_halt.
REQ-002 SHALL have i_clk  input  1  rising-edge clock.
REQ-003 SHALL have i_reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have i_stall  input  1  pipeline stall; MEM slot frozen.
REQ-005 SHALL have i_kill_ex  input  1  EX-stage instruction squashed.
REQ-006 SHALL have i_ex_vld  input  1  EX stage holds a valid instruction.
REQ-007 SHALL have i_ex_pc  input  32  EX-stage PC.
REQ-008 SHALL have i_ex_ctrl  input  1  EX instruction is a branch/jump.
REQ-009 SHALL have i_ex_mispred  input  1  EX branch resolved mispredicted.
REQ-010 SHALL have i_cnt_clr  input  1  clear all performance counters.
REQ-011 SHALL have i_cnt_addr  input  2  counter select: 0 cycle, 1 insn, 2 ctrl, 3 mispred.
REQ-012 SHALL have o_insn_vld  output  1  one-cycle commit pulse.
REQ-013 SHALL have o_pc_debug  output  32  committed PC.
REQ-014 SHALL have o_ctrl  output  1  committed instruction is control transfer.
REQ-015 SHALL have o_mispred  output  1  committed control transfer was mispredicted.
REQ-016 SHALL have o_halt  output  1  sticky: HALT_PC has committed.
REQ-017 SHALL have o_cnt_rdata  output  32  selected counter value.

Function
REQ-018 SHALL hold two stage registers, MEM and WB, each {vld, pc, ctrl, mispred}; outputs driven directly from WB.
REQ-019 SHALL load MEM from EX when i_stall=0, vld = i_ex_vld & ~i_kill_ex; MEM SHALL hold when i_stall=1.
REQ-020 SHALL load WB from MEM when i_stall=0; WB SHALL load a bubble (vld=0) when i_stall=1, so each instruction pulses o_insn_vld exactly once.
REQ-021 SHALL give EX-to-commit latency of 2 cycles with no stall, 2+N with N stall cycles.
REQ-022 SHALL drive o_ctrl = wb.vld & wb.ctrl and o_mispred = wb.vld & wb.ctrl & wb.mispred; o_pc_debug SHALL show wb.pc regardless of vld.
REQ-023 SHALL set o_halt the cycle after o_insn_vld=1 with o_pc_debug==HALT_PC and keep it until reset.
REQ-024 SHALL keep 32-bit counters: cycle +1 every non-reset cycle; insn, ctrl, mispred +1 when the matching output is 1; all wrap 32'hFFFF_FFFF -> 0.
REQ-025 SHALL give i_cnt_clr priority over increment: counters read 0 the next cycle.
REQ-026 SHALL register o_cnt_rdata: value of the counter selected by i_cnt_addr, as held at that edge (pre-increment), visible one cycle later.
REQ-027 SHALL treat i_kill_ex with i_stall=1 as no effect (MEM holds).

Reset
REQ-028 SHALL, while i_reset=0, clear MEM/WB vld, pc, ctrl, mispred, o_halt, all counters and o_cnt_rdata to 0; all outputs read 0 the cycle after.
REQ-029 SHALL discard in-flight MEM/WB instructions on reset mid-operation; the first commit after release needs a fresh EX entry plus 2 cycles.

Configuration
REQ-030 SHALL compile counters and read port in only when COMMIT_PERF_CNT_EN is defined.
REQ-031 SHALL, without COMMIT_PERF_CNT_EN, tie o_cnt_rdata to 0, ignore i_cnt_clr/i_cnt_addr, and keep trace and halt behaviour cycle-identical.

Structure
REQ-032 SHALL place commit_entry_t struct {vld, pc, ctrl, mispred}, counter-select enum and reset constants in package commit_pkg.
REQ-033 SHALL implement counters and read mux in sub-module commit_perf_cnt, instantiated only under COMMIT_PERF_CNT_EN.

Verification
REQ-034 SHALL cover: EX vld pc=0x40 ctrl=0 at cycle t, no stall -> o_insn_vld=1, o_pc_debug=0x40 at t+2 only.
REQ-035 SHALL cover: EX pc=0x80 ctrl=1 mispred=1, i_stall=1 for 3 cycles -> single commit pulse at t+5, o_ctrl=1, o_mispred=1; o_mispred=0 for ctrl=0 mispred=1.
REQ-036 SHALL cover: i_kill_ex=1 with i_ex_vld=1 -> no commit; HALT_PC 0x1C committed -> o_halt=1 next cycle, held.
REQ-037 SHALL cover: 10 commits, 4 ctrl, 1 mispred, i_cnt_addr=1..3 -> o_cnt_rdata 10, 4, 1; i_cnt_clr during commit -> 0 next cycle.
REQ-038 SHALL cover: i_reset=0 with MEM/WB full -> no commit after release, counters 0; cycle counter preset near wrap -> 0xFFFFFFFF then 0.
